mul_cdb_queue: RTL

- Result buffer directly downstream of the pipelined multiplier's CDB-side outputs; the multiplier issues one op per cycle, has a fixed latency of STAGE cycles and cannot stall.
- Captures every valid multiplier result, holds it until the CDB arbiter grants the multiplier slot, then broadcasts it in issue order.
- Drives a credit signal back to the multiply reservation station, so the in-flight plus buffered result count can never exceed DEPTH.

---
 rtl/mul_cdb_queue_if.sv | 44 ++++
 rtl/mul_cdb_queue.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mul_cdb_queue_if.sv
// mul_cdb_queue_if: bundle between the multiplier/RS/CDB arbiter side and
// the multiplier result queue.
//   master : upstream/arbiter side (drives mul_*, squash, cdb_grant)
//   slave  : the queue (drives cdb_*, mul_issue_ok, q_count, overflow_err)
interface mul_cdb_queue_if #(
  parameter int DEPTH   = 16,
  parameter int XLEN    = 32,
  parameter int PRF_LEN = 6,
  parameter int ROB_LEN = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               mul_enable;
  logic               mul_valid;
  logic [XLEN-1:0]    mul_value;
  logic [PRF_LEN-1:0] mul_prf_idx;
  logic [ROB_LEN-1:0] mul_rob_idx;
  logic [XLEN-1:0]    mul_PC;
  logic               squash;
  logic               cdb_grant;

  logic               cdb_req;
  logic [XLEN-1:0]    cdb_value;
  logic [PRF_LEN-1:0] cdb_prf_idx;
  logic [ROB_LEN-1:0] cdb_rob_idx;
  logic [XLEN-1:0]    cdb_PC;
  logic               mul_issue_ok;
  logic [CW-1:0]      q_count;
  logic               overflow_err;

  modport master (
    output mul_enable, mul_valid, mul_value, mul_prf_idx, mul_rob_idx, mul_PC,
           squash, cdb_grant,
    input  cdb_req, cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC,
           mul_issue_ok, q_count, overflow_err
  );

  modport slave (
    input  mul_enable, mul_valid, mul_value, mul_prf_idx, mul_rob_idx, mul_PC,
           squash, cdb_grant,
    output cdb_req, cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC,
           mul_issue_ok, q_count, overflow_err
  );
endinterface

// File: rtl/mul_cdb_queue.sv
// mul_cdb_queue: result buffer behind the pipelined multiplier. Captures
// every live multiplier result, broadcasts in issue order when the CDB
// arbiter grants, and returns an issue credit to the multiply RS so that
// in-flight + buffered results never exceed DEPTH.
//
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   bus (slave)  : mul_* result inputs, mul_enable (issue), squash,
//                  cdb_grant in; cdb_* head entry, cdb_req, mul_issue_ok,
//                  q_count, overflow_err out
//
// Build option: define MUL_CDB_BYPASS_EN to let a result arriving at an
// empty queue be presented on the CDB in the same cycle (and skip storage
// if granted). Without it all outputs are registered.
module mul_cdb_queue #(
  parameter int DEPTH   = 16,
  parameter int STAGE   = 8,
  parameter int XLEN    = 32,
  parameter int PRF_LEN = 6,
  parameter int ROB_LEN = 5
) (
  input logic           clock,
  input logic           reset,
  mul_cdb_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DEPTH < STAGE + 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("mul_cdb_queue: DEPTH must be a power of two and >= STAGE+1");
    end
  endgenerate

  typedef struct packed {
    logic [XLEN-1:0]    value;
    logic [PRF_LEN-1:0] prf_idx;
    logic [ROB_LEN-1:0] rob_idx;
    logic [XLEN-1:0]    pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] q_cnt, inflight, drop_cnt;
  logic          req_r, issue_ok_r, ovf_r;
  entry_t        out_r;

  entry_t        in_e, out_nx, cdb_e;
  logic          push_try, push, pop, full, byp_take, cdb_req, ovf_set;
  logic [AW-1:0] head_nx, tail_nx;
  logic [CW-1:0] q_nx, keep_cnt, inflight_nx, drop_nx;
  logic [CW:0]   credit_sum;

  assign in_e = '{value: bus.mul_value, prf_idx: bus.mul_prf_idx,
                  rob_idx: bus.mul_rob_idx, pc: bus.mul_PC};

  // Results are only live when no squashed ops remain in the multiplier.
  assign push_try = bus.mul_valid && drop_cnt == '0 && !bus.squash;
  assign full     = q_cnt == CW'(DEPTH);
  // A grant in the squash cycle must not pop: the head is already dead.
  assign pop      = req_r && bus.cdb_grant && !bus.squash;

`ifdef MUL_CDB_BYPASS_EN
  logic byp;
  assign byp      = push_try && q_cnt == '0;
  assign byp_take = byp && bus.cdb_grant;
  assign cdb_e    = byp ? in_e : out_r;
  assign cdb_req  = byp | req_r;
`else
  assign byp_take = 1'b0;
  assign cdb_e    = out_r;
  assign cdb_req  = req_r;
`endif

  // Full queue still accepts when the head leaves in the same cycle.
  assign push     = push_try && !byp_take && (!full || pop);
  assign ovf_set  = push_try && !byp_take && full && !pop;

  assign head_nx  = bus.squash ? tail : head + AW'(pop);
  assign tail_nx  = tail + AW'(push);
  assign q_nx     = bus.squash ? '0 : q_cnt + CW'(push) - CW'(pop);
  assign keep_cnt = q_cnt - CW'(pop);

  // The new head is the incoming result when nothing older survives.
  assign out_nx   = (push && keep_cnt == '0) ? in_e : mem[head_nx];

  // Saturate at zero so a result that outlives a reset cannot wrap the
  // counter and choke the credit.
  always_comb begin
    inflight_nx = inflight;
    if (bus.mul_enable && !bus.mul_valid)
      inflight_nx = inflight + 1'b1;
    else if (!bus.mul_enable && bus.mul_valid && inflight != '0)
      inflight_nx = inflight - 1'b1;
  end

  // Squash reloads (never accumulates) with whatever is still in the pipe.
  always_comb begin
    drop_nx = drop_cnt;
    if (bus.squash)
      drop_nx = inflight_nx;
    else if (bus.mul_valid && drop_cnt != '0)
      drop_nx = drop_cnt - 1'b1;
  end

  assign credit_sum = {1'b0, q_nx} + {1'b0, inflight_nx};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      q_cnt      <= '0;
      inflight   <= '0;
      drop_cnt   <= '0;
      req_r      <= 1'b0;
      out_r      <= '0;
      issue_ok_r <= 1'b1;
      ovf_r      <= 1'b0;
    end else begin
      head       <= head_nx;
      tail       <= tail_nx;
      q_cnt      <= q_nx;
      inflight   <= inflight_nx;
      drop_cnt   <= drop_nx;
      req_r      <= q_nx != '0;
      out_r      <= out_nx;
      issue_ok_r <= credit_sum < (CW+1)'(DEPTH);
      ovf_r      <= ovf_r | ovf_set;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[tail] <= in_e;
  end

  assign bus.cdb_req      = cdb_req;
  assign bus.cdb_value    = cdb_e.value;
  assign bus.cdb_prf_idx  = cdb_e.prf_idx;
  assign bus.cdb_rob_idx  = cdb_e.rob_idx;
  assign bus.cdb_PC       = cdb_e.pc;
  assign bus.mul_issue_ok = issue_ok_r;
  assign bus.q_count      = q_cnt;
  assign bus.overflow_err = ovf_r;
endmodule
